// File: rtl/cpu_mem_responder.sv
// Word-addressed RAM slave for the CPU memory master port.
// Combinational wait, optional write stall, fixed-latency in-order read returns,
// bounded read concurrency and a sticky protocol-error flag.
module cpu_mem_responder #(
  parameter int DW             = 16,
  parameter int AW             = 8,
  parameter int RD_LATENCY     = 2,
  parameter int MAX_PENDING    = 4,
  parameter int WR_WAIT_CYCLES = 1
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [AW-1:0] i_mem_addr,
  input  logic          i_mem_rd,
  input  logic          i_mem_wr,
  input  logic [DW-1:0] i_mem_wrdata,
  output logic          o_mem_wait,
  output logic          o_mem_rddatavalid,
  output logic [DW-1:0] o_mem_rddata,
  output logic [2:0]    o_pending,
  output logic          o_protocol_err
);

  // Stall counter only has to hold WR_WAIT_CYCLES-1.
  localparam int          CW       = (WR_WAIT_CYCLES > 1) ? $clog2(WR_WAIT_CYCLES) : 1;
  localparam logic [2:0]  PEND_MAX = 3'(MAX_PENDING);

  typedef enum logic {S_IDLE, S_WR_STALL} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            wr_acc, rd_acc, err_set;

  logic [DW-1:0]   mem [0:(1<<AW)-1];
  logic [RD_LATENCY:1] vld_pipe;
  logic [DW-1:0]   dat_pipe [RD_LATENCY:1];

  assign o_mem_rddatavalid = vld_pipe[RD_LATENCY];
  assign o_mem_rddata      = dat_pipe[RD_LATENCY];

  // Next-state, wait and acceptance decode. A read is only ever taken in
  // S_IDLE with no write present; the slot check uses registered o_pending.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    o_mem_wait = 1'b0;
    wr_acc     = 1'b0;
    rd_acc     = 1'b0;
    err_set    = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_mem_wr) begin
          err_set = i_mem_rd;
          if (WR_WAIT_CYCLES == 0) begin
            wr_acc = 1'b1;
          end else begin
            o_mem_wait = 1'b1;
            cnt_nxt    = CW'(WR_WAIT_CYCLES - 1);
            state_nxt  = S_WR_STALL;
          end
        end else if (i_mem_rd) begin
          if (o_pending == PEND_MAX) o_mem_wait = 1'b1;
          else                       rd_acc     = 1'b1;
        end
      end
      S_WR_STALL: begin
        if (!i_mem_wr) begin
          // Master abandoned the write: drop it and flag the violation.
          o_mem_wait = 1'b1;
          err_set    = 1'b1;
          state_nxt  = S_IDLE;
        end else if (cnt != '0) begin
          o_mem_wait = 1'b1;
          cnt_nxt    = cnt - 1'b1;
        end else begin
          wr_acc    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM and stall counter registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // RAM write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (wr_acc && !i_reset) mem[i_mem_addr] <= i_mem_wrdata;
  end

  // Read pipeline: data is captured at acceptance so later writes cannot
  // disturb reads already in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      vld_pipe <= '0;
      for (int i = 1; i <= RD_LATENCY; i++) dat_pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= rd_acc;
      dat_pipe[1] <= mem[i_mem_addr];
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        dat_pipe[i] <= dat_pipe[i-1];
      end
    end
  end

  // Reads in flight: +1 on accept, -1 on return.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_pending <= '0;
    end else begin
      case ({rd_acc, o_mem_rddatavalid})
        2'b10:   o_pending <= o_pending + 3'd1;
        2'b01:   o_pending <= o_pending - 3'd1;
        default: o_pending <= o_pending;
      endcase
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      o_protocol_err <= 1'b0;
    else if (err_set) o_protocol_err <= 1'b1;
  end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: two configurations driven side by side, a
// cycle-level reference model that pushes expected read returns into a
// scoreboard, and a monitor that pops them when the DUT returns data.
module tb_cpu_mem_responder;

  localparam int L0 = 2, MP0 = 4, WW0 = 1;
  localparam int L1 = 3, MP1 = 1, WW1 = 0;

  logic        clk, rst;
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [7:0]  addr_s [2];
  logic [15:0] wd_s   [2];
  logic        wait_s [2];
  logic        rdv_s  [2];
  logic [15:0] rdd_s  [2];
  logic [2:0]  pend_s [2];
  logic        err_s  [2];

  int nvec, nfail, cyc;

  cpu_mem_responder #(.DW(16), .AW(8), .RD_LATENCY(L0), .MAX_PENDING(MP0),
                      .WR_WAIT_CYCLES(WW0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_mem_addr(addr_s[0]), .i_mem_rd(rd_s[0]),
    .i_mem_wr(wr_s[0]), .i_mem_wrdata(wd_s[0]), .o_mem_wait(wait_s[0]),
    .o_mem_rddatavalid(rdv_s[0]), .o_mem_rddata(rdd_s[0]),
    .o_pending(pend_s[0]), .o_protocol_err(err_s[0]));

  cpu_mem_responder #(.DW(16), .AW(8), .RD_LATENCY(L1), .MAX_PENDING(MP1),
                      .WR_WAIT_CYCLES(WW1)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_mem_addr(addr_s[1]), .i_mem_rd(rd_s[1]),
    .i_mem_wr(wr_s[1]), .i_mem_wrdata(wd_s[1]), .o_mem_wait(wait_s[1]),
    .o_mem_rddatavalid(rdv_s[1]), .o_mem_rddata(rdd_s[1]),
    .o_pending(pend_s[1]), .o_protocol_err(err_s[1]));

  function automatic int lat(input int k);  return (k == 0) ? L0  : L1;  endfunction
  function automatic int maxp(input int k); return (k == 0) ? MP0 : MP1; endfunction
  function automatic int wrw(input int k);  return (k == 0) ? WW0 : WW1; endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  // Reference state: RAM image, accept history (sliding window gives reads in
  // flight), write-wait progress, expected sticky error, scoreboard ring.
  logic [15:0] mem_m   [2][256];
  bit          acc_h   [2][8];
  int          wr_seen [2];
  bit          err_exp [2];
  logic [15:0] sb_d    [2][32];
  int          sb_due  [2][32];
  int          sb_h    [2];
  int          sb_t    [2];

  // Model: predict wait / pending / error, apply accepted requests, push
  // expected read returns with their due cycle.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int pend;
      bit ew, racc;
      if (rst) begin
        for (int j = 0; j < 8; j++) acc_h[k][j] = 1'b0;
        wr_seen[k] = 0;
        err_exp[k] = 1'b0;
        continue;
      end
      pend = 0;
      for (int j = 1; j <= lat(k); j++) pend += int'(acc_h[k][(cyc + 8 - j) % 8]);
      check("pending", k, 32'(pend_s[k]), 32'(pend));
      check("proto_err", k, 32'(err_s[k]), 32'(err_exp[k]));
      racc = 1'b0;
      if (rd_s[k] || wr_s[k]) begin
        if (wr_s[k]) ew = (wr_seen[k] < wrw(k));
        else         ew = (pend == maxp(k));
        check("wait", k, 32'(wait_s[k]), 32'(ew));
        if (wr_s[k]) begin
          if (rd_s[k]) err_exp[k] = 1'b1;
          if (ew) wr_seen[k]++;
          else begin
            mem_m[k][addr_s[k]] = wd_s[k];
            wr_seen[k] = 0;
          end
        end else if (!ew) begin
          racc = 1'b1;
          sb_d[k][sb_t[k] % 32]   = mem_m[k][addr_s[k]];
          sb_due[k][sb_t[k] % 32] = cyc + lat(k);
          sb_t[k]++;
        end
      end else begin
        wr_seen[k] = 0;
      end
      acc_h[k][cyc % 8] = racc;
    end
  end

  // Monitor: pops the scoreboard whenever a read return appears.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        check("rst_rdvalid", k, 32'(rdv_s[k]), 32'd0);
        check("rst_rddata", k, 32'(rdd_s[k]), 32'd0);
        check("rst_pending", k, 32'(pend_s[k]), 32'd0);
        sb_h[k] = sb_t[k];
        continue;
      end
      while (sb_h[k] != sb_t[k] && sb_due[k][sb_h[k] % 32] < cyc) begin
        nvec++; nfail++;
        $display("FAIL missing_return dut%0d cyc %0d: no rddatavalid, expected at cyc %0d",
                 k, cyc, sb_due[k][sb_h[k] % 32]);
        sb_h[k]++;
      end
      if (rdv_s[k]) begin
        if (sb_h[k] == sb_t[k]) begin
          nvec++; nfail++;
          $display("FAIL spurious_return dut%0d cyc %0d: rddatavalid=1 data %0h, expected none",
                   k, cyc, rdd_s[k]);
        end else begin
          check("ret_cycle", k, 32'(cyc), 32'(sb_due[k][sb_h[k] % 32]));
          check("rddata", k, 32'(rdd_s[k]), 32'(sb_d[k][sb_h[k] % 32]));
          sb_h[k]++;
        end
      end
    end
  end

  // Master request: hold until wait drops (bounded), then release after the edge.
  task automatic req(input int k, input bit r, input bit w, input logic [7:0] a,
                     input logic [15:0] d);
    int n = 0;
    rd_s[k] = r; wr_s[k] = w; addr_s[k] = a; wd_s[k] = d;
    @(negedge clk);
    while (wait_s[k] && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("req_timeout", k, 32'(wait_s[k]), 32'd0);
    @(posedge clk); #1;
    rd_s[k] = 1'b0; wr_s[k] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic directed(input int k);
    req(k, 0, 1, 8'h10, 16'hBEEF);
    req(k, 1, 0, 8'h10, 16'h0);
    idle(4);
    for (int a = 0; a < 6; a++) req(k, 1, 0, 8'(a), 16'h0);
    idle(4);
    req(k, 0, 1, 8'h20, 16'h1234);
    req(k, 1, 0, 8'h20, 16'h0);
    req(k, 1, 0, 8'h21, 16'h0);
    req(k, 0, 1, 8'h21, 16'h7777);
    req(k, 1, 0, 8'h21, 16'h0);
    idle(5);
  endtask

  task automatic rnd(input int k);
    for (int i = 0; i < 300; i++) begin
      int r = $urandom_range(0, 99);
      logic [7:0] a = 8'($urandom_range(0, 15));
      if (r < 50)      req(k, 1, 0, a, 16'h0);
      else if (r < 85) req(k, 0, 1, a, 16'($urandom));
      else             idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    nvec = 0; nfail = 0; cyc = 0;
    for (int k = 0; k < 2; k++) begin
      rd_s[k] = 1'b0; wr_s[k] = 1'b0; addr_s[k] = '0; wd_s[k] = '0;
      sb_h[k] = 0; sb_t[k] = 0; wr_seen[k] = 0; err_exp[k] = 1'b0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    // Give every word a known value.
    fork
      for (int a = 0; a < 256; a++) req(0, 0, 1, 8'(a), 16'($urandom));
      for (int a = 0; a < 256; a++) req(1, 0, 1, 8'(a), 16'($urandom));
    join
    fork
      directed(0);
      directed(1);
    join
    fork
      rnd(0);
      rnd(1);
    join
    idle(8);
    // Simultaneous rd & wr: write happens, no return, error sticks.
    fork
      req(0, 1, 1, 8'h30, 16'h5A5A);
      req(1, 1, 1, 8'h30, 16'h5A5A);
    join
    idle(3);
    fork
      req(0, 1, 0, 8'h30, 16'h0);
      req(1, 1, 0, 8'h30, 16'h0);
    join
    idle(6);
    // Reset with two reads in flight on dut0.
    req(0, 1, 0, 8'h01, 16'h0);
    req(0, 1, 0, 8'h02, 16'h0);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(6);
    // Reset while a write is stalled: the write must be dropped.
    wr_s[0] = 1'b1; addr_s[0] = 8'h03; wd_s[0] = 16'hDEAD;
    idle(1);
    wr_s[0] = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    fork
      req(0, 1, 0, 8'h03, 16'h0);
      req(1, 1, 0, 8'h03, 16'h0);
    join
    idle(8);
    for (int k = 0; k < 2; k++) check("drain", k, 32'(sb_t[k] - sb_h[k]), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
